// File: rtl/instr_fetch_unit_if.sv
// rtl/instr_fetch_unit_if.sv - instruction memory req/ready fetch bus
interface instr_fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rdata
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - MIPS fetch stage: PC, imem handshake, skid and IF/ID register
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
    input  logic                       clk,
    input  logic                       rst,
    instr_fetch_unit_if.master         imem,
    input  logic                       id_stall,
    input  logic                       redirect,
    input  logic [31:0]                redirect_pc,
    output logic                       if_valid,
    output logic [31:0]                if_instr,
    output logic [31:0]                if_pc,
    output logic [31:0]                if_pc4,
    output logic [5:0]                 op,
    output logic [5:0]                 func,
    output logic [31:0]                fetch_count
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_SKID = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_next_state;
    logic [31:0] r_pc;
    logic [31:0] r_hold_addr;
    logic        r_squash;
    logic        r_if_valid;
    logic [31:0] r_if_instr;
    logic [31:0] r_if_pc;
    logic [31:0] r_skid_instr;
    logic [31:0] r_skid_pc;
    logic [31:0] r_fetch_count;

    logic        w_hs;
    logic        w_slot_free;
    logic        w_consume;
    logic [31:0] w_redirect_pc;

    assign w_hs          = (r_state == S_REQ) && imem.imem_ready;
    assign w_slot_free   = !r_if_valid || !id_stall;
    assign w_consume     = r_if_valid && !id_stall;
    assign w_redirect_pc = redirect_pc & ~32'h3;

    // A squashed request keeps presenting its original address until memory takes it.
    assign imem.imem_req  = (r_state == S_REQ);
    assign imem.imem_addr = r_squash ? r_hold_addr : r_pc;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: w_next_state = S_REQ;
            S_REQ: begin
                if (!redirect && w_hs && !r_squash && !w_slot_free) begin
                    w_next_state = S_SKID;
                end
            end
            S_SKID: begin
                if (redirect || w_slot_free) begin
                    w_next_state = S_REQ;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_pc          <= RESET_PC;
            r_hold_addr   <= RESET_PC;
            r_squash      <= 1'b0;
            r_if_valid    <= 1'b0;
            r_if_instr    <= NOP_WORD;
            r_if_pc       <= 32'h0;
            r_skid_instr  <= NOP_WORD;
            r_skid_pc     <= 32'h0;
            r_fetch_count <= 32'h0;
        end else begin
            if (w_consume) begin
                r_fetch_count <= r_fetch_count + 32'd1;
            end
            if (redirect) begin
                r_if_valid <= 1'b0;
                r_pc       <= w_redirect_pc;
                if ((r_state == S_REQ) && !imem.imem_ready) begin
                    r_squash <= 1'b1;
                    if (!r_squash) begin
                        r_hold_addr <= r_pc;
                    end
                end else begin
                    r_squash <= 1'b0;
                end
            end else if (w_hs) begin
                if (r_squash) begin
                    r_squash <= 1'b0;
                    if (w_consume) begin
                        r_if_valid <= 1'b0;
                    end
                end else if (w_slot_free) begin
                    r_if_valid <= 1'b1;
                    r_if_instr <= imem.imem_rdata;
                    r_if_pc    <= r_pc;
                    r_pc       <= r_pc + 32'd4;
                end else begin
                    r_skid_instr <= imem.imem_rdata;
                    r_skid_pc    <= r_pc;
                    r_pc         <= r_pc + 32'd4;
                end
            end else if ((r_state == S_SKID) && w_slot_free) begin
                r_if_valid <= 1'b1;
                r_if_instr <= r_skid_instr;
                r_if_pc    <= r_skid_pc;
            end else if (w_consume) begin
                r_if_valid <= 1'b0;
            end
        end
    end

    assign if_valid    = r_if_valid;
    assign if_instr    = r_if_valid ? r_if_instr : NOP_WORD;
    assign if_pc       = r_if_pc;
    assign if_pc4      = r_if_pc + 32'd4;
    assign op          = if_instr[31:26];
    assign func        = if_instr[5:0];
    assign fetch_count = r_fetch_count;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - directed-vector bench for instr_fetch_unit
module tb_instr_fetch_unit;

    logic        clk;
    logic        rst;
    logic        id_stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        mem_ready;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic [31:0] if_pc4;
    logic [5:0]  op;
    logic [5:0]  func;
    logic [31:0] fetch_count;

    int vectors;
    int miscompares;

    instr_fetch_unit_if bus ();

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a == 32'h10) ? 32'h8C22_0004 : (32'hA500_0000 ^ a);
    endfunction

    assign bus.imem_ready = mem_ready;
    assign bus.imem_rdata = mem_word(bus.imem_addr);

    instr_fetch_unit #(
        .RESET_PC(32'h0000_0000),
        .NOP_WORD(32'h0000_0000)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .imem        (bus.master),
        .id_stall    (id_stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .if_valid    (if_valid),
        .if_instr    (if_instr),
        .if_pc       (if_pc),
        .if_pc4      (if_pc4),
        .op          (op),
        .func        (func),
        .fetch_count (fetch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; id_stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0; mem_ready = 1'b1;
        step();
        step();
        vectors++; if (bus.imem_req !== 1'b0) begin miscompares++; $display("FAIL reset_req got %b exp 0", bus.imem_req); end
        vectors++; if (bus.imem_addr !== 32'h0) begin miscompares++; $display("FAIL reset_addr got %h exp 0", bus.imem_addr); end
        vectors++; if (if_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid got %b exp 0", if_valid); end
        vectors++; if (if_instr !== 32'h0) begin miscompares++; $display("FAIL reset_instr got %h exp 0", if_instr); end
        vectors++; if (if_pc !== 32'h0 || if_pc4 !== 32'h4) begin miscompares++; $display("FAIL reset_pc got %h/%h exp 0/4", if_pc, if_pc4); end
        vectors++; if (fetch_count !== 32'h0) begin miscompares++; $display("FAIL reset_count got %0d exp 0", fetch_count); end
    endtask

    task automatic test_stream();
        rst = 1'b1;
        step();
        vectors++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0) begin miscompares++; $display("FAIL stream_first_req got %b/%h exp 1/0", bus.imem_req, bus.imem_addr); end
        vectors++; if (if_valid !== 1'b0) begin miscompares++; $display("FAIL stream_first_valid got %b exp 0", if_valid); end
        for (int k = 0; k < 6; k++) begin
            step();
            vectors++; if (bus.imem_addr !== 32'(4 * (k + 1))) begin miscompares++; $display("FAIL stream_addr[%0d] got %h exp %h", k, bus.imem_addr, 4 * (k + 1)); end
            vectors++; if (if_valid !== 1'b1 || if_pc !== 32'(4 * k)) begin miscompares++; $display("FAIL stream_pc[%0d] got %b/%h exp 1/%h", k, if_valid, if_pc, 4 * k); end
            vectors++; if (if_instr !== mem_word(32'(4 * k))) begin miscompares++; $display("FAIL stream_instr[%0d] got %h exp %h", k, if_instr, mem_word(32'(4 * k))); end
            vectors++; if (fetch_count !== 32'(k)) begin miscompares++; $display("FAIL stream_count[%0d] got %0d exp %0d", k, fetch_count, k); end
            if (k == 4) begin
                vectors++; if (op !== 6'b100011 || func !== 6'b000100) begin miscompares++; $display("FAIL decode_fields got %b/%b exp 100011/000100", op, func); end
                vectors++; if (if_pc4 !== 32'h14) begin miscompares++; $display("FAIL decode_pc4 got %h exp 14", if_pc4); end
            end
        end
    endtask

    task automatic test_stall_skid();
        id_stall = 1'b1;
        step();
        vectors++; if (bus.imem_req !== 1'b0) begin miscompares++; $display("FAIL skid_req got %b exp 0", bus.imem_req); end
        vectors++; if (if_pc !== 32'h14 || if_valid !== 1'b1) begin miscompares++; $display("FAIL skid_hold got %b/%h exp 1/14", if_valid, if_pc); end
        step();
        step();
        vectors++; if (bus.imem_req !== 1'b0 || if_pc !== 32'h14 || fetch_count !== 32'd5) begin miscompares++; $display("FAIL skid_stalled got %b/%h/%0d exp 0/14/5", bus.imem_req, if_pc, fetch_count); end
        id_stall = 1'b0;
        step();
        vectors++; if (if_pc !== 32'h18 || if_instr !== mem_word(32'h18)) begin miscompares++; $display("FAIL skid_drain got %h/%h exp 18/%h", if_pc, if_instr, mem_word(32'h18)); end
        vectors++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h1c || fetch_count !== 32'd6) begin miscompares++; $display("FAIL skid_rereq got %b/%h/%0d exp 1/1c/6", bus.imem_req, bus.imem_addr, fetch_count); end
        step();
        vectors++; if (if_pc !== 32'h1c || fetch_count !== 32'd7) begin miscompares++; $display("FAIL skid_next got %h/%0d exp 1c/7", if_pc, fetch_count); end
    endtask

    task automatic test_squash();
        mem_ready = 1'b0; redirect = 1'b1; redirect_pc = 32'h40;
        step();
        redirect = 1'b0;
        vectors++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h20) begin miscompares++; $display("FAIL squash_hold got %b/%h exp 1/20", bus.imem_req, bus.imem_addr); end
        vectors++; if (if_valid !== 1'b0 || fetch_count !== 32'd8) begin miscompares++; $display("FAIL squash_flush got %b/%0d exp 0/8", if_valid, fetch_count); end
        step();
        vectors++; if (bus.imem_addr !== 32'h20 || if_valid !== 1'b0) begin miscompares++; $display("FAIL squash_hold2 got %h/%b exp 20/0", bus.imem_addr, if_valid); end
        mem_ready = 1'b1;
        step();
        vectors++; if (if_valid !== 1'b0 || bus.imem_addr !== 32'h40 || bus.imem_req !== 1'b1) begin miscompares++; $display("FAIL squash_discard got %b/%h/%b exp 0/40/1", if_valid, bus.imem_addr, bus.imem_req); end
        step();
        vectors++; if (if_valid !== 1'b1 || if_pc !== 32'h40 || fetch_count !== 32'd8) begin miscompares++; $display("FAIL squash_target got %b/%h/%0d exp 1/40/8", if_valid, if_pc, fetch_count); end
    endtask

    task automatic test_redirect_hs();
        id_stall = 1'b1; redirect = 1'b1; redirect_pc = 32'h103;
        step();
        redirect = 1'b0; id_stall = 1'b0;
        vectors++; if (if_valid !== 1'b0 || if_instr !== 32'h0) begin miscompares++; $display("FAIL redir_flush got %b/%h exp 0/0", if_valid, if_instr); end
        vectors++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h100) begin miscompares++; $display("FAIL redir_addr got %b/%h exp 1/100", bus.imem_req, bus.imem_addr); end
        step();
        vectors++; if (if_pc !== 32'h100 || if_valid !== 1'b1 || fetch_count !== 32'd8) begin miscompares++; $display("FAIL redir_target got %h/%b/%0d exp 100/1/8", if_pc, if_valid, fetch_count); end
    endtask

    task automatic test_reset_mid();
        id_stall = 1'b1;
        step();
        vectors++; if (bus.imem_req !== 1'b0) begin miscompares++; $display("FAIL midrst_skid got %b exp 0", bus.imem_req); end
        rst = 1'b0;
        step();
        vectors++; if (bus.imem_req !== 1'b0 || bus.imem_addr !== 32'h0) begin miscompares++; $display("FAIL midrst_bus got %b/%h exp 0/0", bus.imem_req, bus.imem_addr); end
        vectors++; if (if_valid !== 1'b0 || if_instr !== 32'h0 || if_pc !== 32'h0 || if_pc4 !== 32'h4 || fetch_count !== 32'h0) begin miscompares++; $display("FAIL midrst_out got %b/%h/%h/%h/%0d exp 0/0/0/4/0", if_valid, if_instr, if_pc, if_pc4, fetch_count); end
        rst = 1'b1; id_stall = 1'b0;
        step();
        vectors++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0) begin miscompares++; $display("FAIL midrst_restart got %b/%h exp 1/0", bus.imem_req, bus.imem_addr); end
        step();
        vectors++; if (if_valid !== 1'b1 || if_pc !== 32'h0 || if_instr !== mem_word(32'h0)) begin miscompares++; $display("FAIL midrst_first got %b/%h/%h exp 1/0/%h", if_valid, if_pc, if_instr, mem_word(32'h0)); end
    endtask

    task automatic test_pc_wrap();
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        step();
        redirect = 1'b0;
        vectors++; if (bus.imem_addr !== 32'hFFFF_FFFC || fetch_count !== 32'd1) begin miscompares++; $display("FAIL wrap_addr got %h/%0d exp fffffffc/1", bus.imem_addr, fetch_count); end
        step();
        vectors++; if (if_pc !== 32'hFFFF_FFFC || if_pc4 !== 32'h0) begin miscompares++; $display("FAIL wrap_pc4 got %h/%h exp fffffffc/0", if_pc, if_pc4); end
        vectors++; if (bus.imem_addr !== 32'h0) begin miscompares++; $display("FAIL wrap_next got %h exp 0", bus.imem_addr); end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        test_reset();
        test_stream();
        test_stall_skid();
        test_squash();
        test_redirect_hs();
        test_reset_mid();
        test_pc_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
Instruction-fetch stage feeding the op/func decoder of the single-issue MIPS pipeline. It owns the PC, fetches 32-bit words from instruction memory over a req/ready handshake, and presents one instruction per cycle in an IF/ID output register. The output register exposes op and func fields to the control unit. Redirects from downstream branch/jump resolution squash wrong-path fetches.

Parameters:
RESET_PC, 32'h0000_0000, first fetch address after reset (word aligned)
NOP_WORD, 32'h0000_0000, value driven on if_instr whenever if_valid=0

Ports:
clk  in  1  single clock, all state updates on posedge
rst  in  1  synchronous, active-low reset
imem_req  out  1  fetch request to instruction memory
imem_addr  out  32  fetch word address, bits[1:0] always 0
imem_ready  in  1  memory accepts request and returns imem_rdata this cycle
imem_rdata  in  32  instruction word, valid when imem_req&&imem_ready
id_stall  in  1  decode cannot consume the current IF/ID entry
redirect  in  1  branch taken / jump; flush and refetch
redirect_pc  in  32  target PC; bits[1:0] ignored (forced 0)
if_valid  out  1  IF/ID register holds a live instruction
if_instr  out  32  instruction word (NOP_WORD when !if_valid)
if_pc  out  32  address of if_instr
if_pc4  out  32  if_pc+4, modulo 2^32
op  out  6  if_instr[31:26]
func  out  6  if_instr[5:0]
fetch_count  out  32  count of instructions delivered to decode

Behaviour:
- Reset (clk edge with rst=0): state=IDLE, pc=RESET_PC, imem_req=0, imem_addr=RESET_PC, if_valid=0, if_instr=NOP_WORD, if_pc=0, if_pc4=4, skid empty, squash=0, fetch_count=0. Reset overrides redirect, stall, and an in-flight request; the abandoned request is dropped and memory must tolerate req falling before ready.
- States: IDLE, REQ, SKID.
- IDLE: one cycle after reset; imem_req=0; then go to REQ.
- REQ: imem_req=1, imem_addr=pc. Addr stays stable until imem_ready=1.
- On handshake (req&&ready), when not squashed and no redirect that cycle:
  - Slot free (!if_valid || !id_stall): load if_instr=imem_rdata, if_pc=pc, if_valid=1 next cycle, pc+=4, remain in REQ.
  - Slot occupied and stalled: store word+pc in the skid register, pc+=4, go to SKID.
- Latency: word appears on if_instr the cycle after its handshake. Zero-wait memory gives 1 instr/cycle with a back-to-back req.
- Consumption: the entry is consumed on any edge with if_valid && !id_stall. If no new word loads, if_valid clears to 0.
- SKID: imem_req=0. When the slot frees, the skid moves to IF/ID and the state returns to REQ; the next req is issued that same next cycle.
- Redirect, sampled at posedge (priority over stall and handshake):
  - if_valid cleared next cycle, skid emptied, pc=redirect_pc&~3.
  - In REQ with req high and ready low: the outstanding req must hold its old addr until ready. Set squash=1. The returning word is discarded. The next cycle issues req to the new pc.
  - Redirect coincident with a handshake: that word is discarded and the next req addr is redirect_pc.
  - In SKID: go to REQ with the new pc.
  - Redirect during an id_stall: the flush still occurs.
- fetch_count increments on each consume edge, wraps at 2^32, and is not incremented for discarded or squashed words.
- PC wraps 32'hFFFF_FFFC -> 0. No alignment exception is raised.
- op and func are combinational slices of if_instr. Decoder outputs are qualified by if_valid.

Test Plan:
- Reset, then ready held 1 and stall 0 -> imem_addr 0,4,8,... on consecutive cycles; if_pc trails by one cycle; fetch_count=5 after 5 consumed.
- Word 0x8C220004 at addr 0x10 -> op=6'b100011, func=6'b000100, if_pc=0x10, if_pc4=0x14.
- id_stall=1 for 3 cycles while ready=1 -> one word enters the skid; req drops; after release, words at A and A+4 are delivered in order with no loss or duplication.
- imem_ready low 2 cycles, redirect to 0x40 in the first -> old addr held until ready; returned word is discarded; next req addr=0x40; no if_valid for the wrong path.
- Redirect 0x103 coincident with a handshake and id_stall=1 -> if_valid=0 next cycle; next req addr=0x100.
- Assert rst=0 mid-stream with an entry in the skid -> all outputs return to reset values on that edge; fetch restarts at RESET_PC two cycles after rst=1.
